serial_cmd_initiator: RTL and testbench

Host-side initiator for the board's one-byte-opcode serial command protocol. Takes one command request, serialises the opcode and its optional argument byte onto a UART transmitter, then collects the fixed-length response from a UART receiver. Response bytes are packed into little-endian 32-bit words. Sits between a test/control sequencer (or soft CPU) and a uart_tx/uart_rx pair facing the trigger board.

---
 rtl/serial_cmd_pkg.sv | 44 ++++
 rtl/serial_cmd_initiator_resp_packer.sv | 69 ++++++
 rtl/serial_cmd_initiator.sv | 164 ++++++++++++++++
 tb/tb_serial_cmd_initiator.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_cmd_pkg.sv
// Shared opcode table and FSM state type for the serial command initiator.
package serial_cmd_pkg;

  localparam logic [7:0] OP_VERSION       = 8'd0;
  localparam logic [7:0] OP_DEADTICKS     = 8'd1;
  localparam logic [7:0] OP_FIRINGTICKS   = 8'd2;
  localparam logic [7:0] OP_TOGGLE_EN     = 8'd3;
  localparam logic [7:0] OP_TOGGLE_CLKSRC = 8'd4;
  localparam logic [7:0] OP_SET_PHASE     = 8'd5;
  localparam logic [7:0] OP_MASK1         = 8'd6;
  localparam logic [7:0] OP_MASK2         = 8'd7;
  localparam logic [7:0] OP_PASSTHRU      = 8'd8;
  localparam logic [7:0] OP_READ_HIST     = 8'd10;
  localparam logic [7:0] OP_TOGGLE_VETO   = 8'd11;
  localparam logic [7:0] OP_RESET_PLL     = 8'd13;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TX_OP,
    ST_TX_OP_GAP,
    ST_TX_ARG,
    ST_TX_ARG_GAP,
    ST_RX,
    ST_FINISH
  } state_e;

  // Opcodes followed by one argument byte on the wire.
  function automatic logic op_has_arg(input logic [7:0] op);
    case (op)
      OP_DEADTICKS, OP_FIRINGTICKS, OP_SET_PHASE, OP_MASK1, OP_MASK2: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Number of response bytes the responder returns; unknown ops return none.
  function automatic logic [7:0] op_resp_len(input logic [7:0] op);
    case (op)
      OP_VERSION:   return 8'd1;
      OP_READ_HIST: return 8'd16;
      default:      return 8'd0;
    endcase
  endfunction

endpackage

// File: rtl/serial_cmd_initiator_resp_packer.sv
// Packs received bytes little-endian into 32-bit words; flushes a partial
// word when the final byte arrives, zero-filling the unused upper lanes.
module resp_packer (
  input  logic        clk,
  input  logic        rstn,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  input  logic        byte_last,
  output logic        word_valid,
  output logic [31:0] word,
  output logic        word_last
);

  logic [1:0]  lane_q, lane_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] word_q, word_d;
  logic        valid_q, valid_d;
  logic        last_q, last_d;
  logic [31:0] merged;

  // Accumulate bytes into the current lane and emit on lane 3 or final byte.
  always_comb begin
    lane_d  = lane_q;
    acc_d   = acc_q;
    word_d  = word_q;
    valid_d = 1'b0;
    last_d  = 1'b0;
    merged  = acc_q;
    if (clear) begin
      lane_d = '0;
      acc_d  = '0;
    end else if (byte_valid) begin
      merged[{lane_q, 3'b000} +: 8] = byte_data;
      if (lane_q == 2'd3 || byte_last) begin
        word_d  = merged;
        valid_d = 1'b1;
        last_d  = byte_last;
        acc_d   = '0;
        lane_d  = '0;
      end else begin
        acc_d  = merged;
        lane_d = lane_q + 2'd1;
      end
    end
  end

  // Packer state registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lane_q  <= '0;
      acc_q   <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      lane_q  <= lane_d;
      acc_q   <= acc_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign word_valid = valid_q;
  assign word       = word_q;
  assign word_last  = last_q;

endmodule

// File: rtl/serial_cmd_initiator.sv
// Host-side initiator: sends opcode (+ optional arg) over UART TX, then
// collects the fixed-length response from UART RX into 32-bit words.
module serial_cmd_initiator
  import serial_cmd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 5000000,
  parameter int unsigned MAX_RESP_BYTES = 16
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_op,
  input  logic [7:0]  cmd_arg,
  input  logic        txBusy,
  output logic        txStart,
  output logic [7:0]  txData,
  input  logic        rxReady,
  input  logic [7:0]  rxData,
  output logic        resp_valid,
  output logic [31:0] resp_word,
  output logic        resp_last,
  output logic        done,
  output logic        timeout_err
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned CW = $clog2(MAX_RESP_BYTES + 1);

  state_e        state_q, state_d;
  logic [7:0]    op_q, op_d;
  logic [7:0]    arg_q, arg_d;
  logic          has_arg_q, has_arg_d;
  logic [CW-1:0] len_q, len_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          tx_start_q, tx_start_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          done_q, done_d;
  logic          terr_q, terr_d;
  logic          pk_clear, pk_valid, pk_last;

  // Next-state and datapath control for the command sequence.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    arg_d      = arg_q;
    has_arg_d  = has_arg_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    tcnt_d     = tcnt_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    terr_d     = terr_q;
    pk_clear   = 1'b0;
    pk_valid   = 1'b0;
    pk_last    = (cnt_q == len_q - CW'(1));
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          op_d      = cmd_op;
          arg_d     = cmd_arg;
          has_arg_d = op_has_arg(cmd_op);
          len_d     = CW'(op_resp_len(cmd_op));
          terr_d    = 1'b0;
          state_d   = ST_TX_OP;
        end
      end
      ST_TX_OP: begin
        if (!txBusy) begin
          tx_data_d  = op_q;
          tx_start_d = 1'b1;
          state_d    = ST_TX_OP_GAP;
        end
      end
      ST_TX_OP_GAP, ST_TX_ARG_GAP: begin
        if (state_q == ST_TX_OP_GAP && has_arg_q) begin
          state_d = ST_TX_ARG;
        end else if (len_q != '0) begin
          cnt_d    = '0;
          tcnt_d   = '0;
          pk_clear = 1'b1;
          state_d  = ST_RX;
        end else begin
          state_d = ST_FINISH;
        end
      end
      ST_TX_ARG: begin
        if (!txBusy) begin
          tx_data_d  = arg_q;
          tx_start_d = 1'b1;
          state_d    = ST_TX_ARG_GAP;
        end
      end
      ST_RX: begin
        // Completion is checked one cycle after the final byte so done
        // trails the last resp_valid pulse.
        if (cnt_q == len_q) begin
          state_d = ST_FINISH;
        end else if (rxReady) begin
          pk_valid = 1'b1;
          cnt_d    = cnt_q + CW'(1);
          tcnt_d   = '0;
        end else if (tcnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
          terr_d  = 1'b1;
          state_d = ST_FINISH;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    done_d = (state_d == ST_FINISH);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      op_q       <= '0;
      arg_q      <= '0;
      has_arg_q  <= 1'b0;
      len_q      <= '0;
      cnt_q      <= '0;
      tcnt_q     <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      done_q     <= 1'b0;
      terr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      arg_q      <= arg_d;
      has_arg_q  <= has_arg_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      tcnt_q     <= tcnt_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      done_q     <= done_d;
      terr_q     <= terr_d;
    end
  end

  resp_packer u_packer (
    .clk        (clk),
    .rstn       (rstn),
    .clear      (pk_clear),
    .byte_valid (pk_valid),
    .byte_data  (rxData),
    .byte_last  (pk_last),
    .word_valid (resp_valid),
    .word       (resp_word),
    .word_last  (resp_last)
  );

  assign cmd_ready   = (state_q == ST_IDLE);
  assign txStart     = tx_start_q;
  assign txData      = tx_data_q;
  assign done        = done_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_serial_cmd_initiator.sv
// Scoreboard bench for serial_cmd_initiator with a behavioural responder.
module tb_serial_cmd_initiator;

  localparam int T = 1000;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [7:0]  cmd_op = '0;
  logic [7:0]  cmd_arg = '0;
  logic        txBusy = 1'b0;
  logic        txStart;
  logic [7:0]  txData;
  logic        rxReady = 1'b0;
  logic [7:0]  rxData = '0;
  logic        resp_valid;
  logic [31:0] resp_word;
  logic        resp_last;
  logic        done;
  logic        timeout_err;

  serial_cmd_initiator #(.TIMEOUT_CYCLES(T), .MAX_RESP_BYTES(16)) dut (
    .clk(clk), .rstn(rstn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_arg(cmd_arg), .txBusy(txBusy), .txStart(txStart),
    .txData(txData), .rxReady(rxReady), .rxData(rxData),
    .resp_valid(resp_valid), .resp_word(resp_word), .resp_last(resp_last),
    .done(done), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  logic [7:0]  exp_tx[$];
  logic [31:0] exp_word[$];
  logic        exp_last[$];
  logic        exp_terr[$];
  logic [7:0]  rb[16];

  int tx_seen = 0, done_seen = 0;
  int done_cyc = -1000, last_tx_cyc = 0, last_resp_cyc = 0;
  int busy_len = 0, busy_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset();
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_txStart", 32'(txStart), 32'd0);
    chk("rst_txData", 32'(txData), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_word", resp_word, 32'd0);
    chk("rst_resp_last", 32'(resp_last), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_timeout_err", 32'(timeout_err), 32'd0);
  endtask

  // Reference opcode table.
  function automatic bit m_has_arg(input int op);
    return (op == 1 || op == 2 || op == 5 || op == 6 || op == 7);
  endfunction

  function automatic int m_len(input int op);
    if (op == 0) return 1;
    if (op == 10) return 16;
    return 0;
  endfunction

  // UART TX model: busy for busy_len cycles after each launch.
  initial forever begin
    @(posedge clk);
    #1;
    if (!rstn) begin
      busy_cnt = 0;
      txBusy = 1'b0;
    end else if (txStart) begin
      chk("tx_launch_while_busy", 32'(txBusy), 32'd0);
      busy_cnt = busy_len;
      txBusy = (busy_cnt > 0);
    end else if (busy_cnt > 0) begin
      busy_cnt--;
      txBusy = (busy_cnt > 0);
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents an output.
  initial forever begin
    @(negedge clk);
    if (rstn) begin
      if (txStart) begin
        tx_seen++;
        last_tx_cyc = cyc;
        if (exp_tx.size() == 0) chk("tx_unexpected", 32'd1, 32'd0);
        else chk("tx_data", 32'(txData), 32'(exp_tx.pop_front()));
      end
      if (resp_valid) begin
        last_resp_cyc = cyc;
        if (exp_word.size() == 0) chk("resp_unexpected", resp_word, 32'hFFFF_FFFF);
        else begin
          chk("resp_word", resp_word, exp_word.pop_front());
          chk("resp_last", 32'(resp_last), 32'(exp_last.pop_front()));
        end
      end else if (resp_last) begin
        chk("resp_last_stray", 32'd1, 32'd0);
      end
      if (done) begin
        done_seen++;
        done_cyc = cyc;
        if (exp_terr.size() == 0) chk("done_unexpected", 32'd1, 32'd0);
        else chk("timeout_err", 32'(timeout_err), 32'(exp_terr.pop_front()));
        chk("words_outstanding", 32'(exp_word.size()), 32'd0);
        chk("tx_outstanding", 32'(exp_tx.size()), 32'd0);
      end
    end
  end

  task automatic run_cmd(input logic [7:0] op, input logic [7:0] arg, input int nreply,
                         input int blen, input int gap0, input bit do_reset,
                         input bit keep_valid, input bit already_valid, input logic [7:0] nxt_op);
    int len, got, nw, ntx, base_tx, base_done, acc_c, byte_c, k;
    bit timed;
    logic [31:0] w;
    len = m_len(int'(op));
    timed = (nreply < len);
    got = timed ? nreply : len;
    nw = timed ? got / 4 : (len + 3) / 4;
    ntx = m_has_arg(int'(op)) ? 2 : 1;
    exp_tx.push_back(op);
    if (ntx == 2) exp_tx.push_back(arg);
    for (int wi = 0; wi < nw; wi++) begin
      w = '0;
      for (int b = 0; b < 4; b++)
        if (4 * wi + b < got) w = w | (32'(rb[4 * wi + b]) << (8 * b));
      exp_word.push_back(w);
      exp_last.push_back(!timed && (wi == nw - 1));
    end
    exp_terr.push_back(timed);
    base_tx = tx_seen;
    base_done = done_seen;
    busy_len = blen;

    if (!already_valid) begin
      k = 0;
      do begin @(negedge clk); k++; end while (!(cmd_ready === 1'b1 && txBusy == 1'b0) && k < 5000);
      if (k >= 5000) chk("idle_wait_expired", 32'd1, 32'd0);
      tick();
      cmd_valid = 1'b1;
      cmd_op = op;
      cmd_arg = arg;
    end
    k = 0;
    do begin @(negedge clk); k++; end while (cmd_ready !== 1'b1 && k < 5000);
    if (k >= 5000) chk("accept_wait_expired", 32'd1, 32'd0);
    acc_c = cyc + 1;
    chk("accept_after_prev_done", 32'(acc_c > done_cyc), 32'd1);
    tick();
    if (keep_valid) begin
      cmd_op = nxt_op;
      cmd_arg = '0;
    end else begin
      cmd_valid = 1'b0;
    end

    k = 0;
    do begin @(negedge clk); #1; k++; end while (tx_seen == base_tx && k < 5000);
    chk("first_tx_latency", 32'(cyc - acc_c), 32'd1);
    k = 0;
    while (tx_seen < base_tx + ntx && k < 5000) begin @(negedge clk); #1; k++; end
    if (k >= 5000) chk("tx_wait_expired", 32'd1, 32'd0);
    k = 0;
    while (txBusy && k < 5000) begin @(negedge clk); k++; end
    repeat (gap0) tick();

    for (int i = 0; i < nreply; i++) begin
      tick();
      rxReady = 1'b1;
      rxData = rb[i];
      byte_c = cyc + 1;
      tick();
      rxReady = 1'b0;
      repeat ($urandom_range(0, 3)) tick();
    end

    if (do_reset) begin
      repeat (2) tick();
      @(negedge clk);
      #2;
      rstn = 1'b0;
      #1;
      chk_reset();
      exp_tx.delete();
      exp_word.delete();
      exp_last.delete();
      exp_terr.delete();
      repeat (2) tick();
      rstn = 1'b1;
      return;
    end

    k = 0;
    while (done_seen == base_done && k < 3 * T) begin @(negedge clk); #1; k++; end
    if (done_seen == base_done) begin
      chk("done_wait_expired", 32'd1, 32'd0);
      return;
    end
    if (timed && nreply > 0) chk("timeout_latency", 32'(done_cyc - byte_c), 32'(T));
    else if (!timed && len > 0) chk("done_after_resp", 32'(done_cyc - last_resp_cyc), 32'd1);
    else if (len == 0) chk("done_after_gap", 32'(done_cyc - last_tx_cyc), 32'd1);
    if (keep_valid) return;

    // Stray byte while idle must be ignored.
    tick();
    rxReady = 1'b1;
    rxData = 8'($urandom);
    tick();
    rxReady = 1'b0;
  endtask

  initial begin
    int op, nr;
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int op, nr;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset();
    tick();
    rstn = 1'b1;
    repeat (2) tick();

    rb[0] = 8'h0D;
    run_cmd(8'h00, 8'h00, 1, 3, 100, 1'b0, 1'b0, 1'b0, 8'h00);
    run_cmd(8'h01, 8'h14, 0, 20, 1, 1'b0, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 16; i++) rb[i] = 8'(i + 1);
    run_cmd(8'h0A, 8'h00, 16, 2, 5, 1'b0, 1'b0, 1'b0, 8'h00);
    run_cmd(8'h0A, 8'h00, 6, 0, 3, 1'b0, 1'b0, 1'b0, 8'h00);
    run_cmd(8'h0A, 8'h00, 3, 1, 2, 1'b1, 1'b0, 1'b0, 8'h00);
    rb[0] = 8'hA7;
    run_cmd(8'h00, 8'h00, 1, 0, 1, 1'b0, 1'b0, 1'b0, 8'h00);
    run_cmd(8'h03, 8'h00, 0, 0, 1, 1'b0, 1'b1, 1'b0, 8'h00);
    rb[0] = 8'h5A;
    run_cmd(8'h00, 8'h00, 1, 0, 1, 1'b0, 1'b0, 1'b1, 8'h00);

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 9) < 3) op = ($urandom_range(0, 1) == 0) ? 0 : 10;
      else op = $urandom_range(0, 15);
      for (int i = 0; i < 16; i++) rb[i] = 8'($urandom);
      nr = m_len(op);
      if (nr > 0 && $urandom_range(0, 4) == 0) nr = $urandom_range(0, nr - 1);
      run_cmd(8'(op), 8'($urandom), nr, $urandom_range(0, 5), $urandom_range(1, 6),
              1'b0, 1'b0, 1'b0, 8'h00);
    end

    repeat (5) tick();
    chk("tx_queue_empty", 32'(exp_tx.size()), 32'd0);
    chk("done_queue_empty", 32'(exp_terr.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
